// File: rtl/johnson_code_monitor.sv
// Receive-side monitor for a Johnson-coded bus: decodes index/one-hot, checks
// code legality and step sequencing, locks on a clean advance and counts wraps.
module johnson_code_monitor #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = 3,
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               clr_err,
  output logic [IDX_W-1:0]   state_idx,
  output logic [2*WIDTH-1:0] one_hot,
  output logic               valid,
  output logic               illegal,
  output logic               seq_err,
  output logic               locked,
  output logic [CNT_W-1:0]   wrap_cnt,
  output logic               sticky_err
);

  localparam int N = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t             r_state, w_state_nx;
  logic [2:0]         r_adv, w_adv_nx;
  logic               r_first, w_first_nx;

  logic [IDX_W-1:0]   w_idx_nx;
  logic [2*WIDTH-1:0] w_oh_nx;
  logic               w_valid_nx, w_ill_nx, w_seq_nx, w_sticky_nx;
  logic [CNT_W-1:0]   w_wrap_nx;

  // Folding the upper half onto the lower half: both halves become a run of
  // ones from bit 0, so legality is "low-order mask" and idx is its popcount.
  logic [WIDTH-1:0]   w_t;
  logic               w_legal;
  logic [IDX_W-1:0]   w_cnt, w_idx, w_inc;
  logic               w_adv_ok, w_hold;

  always_comb begin
    w_t     = q_in[WIDTH-1] ? ~q_in : q_in;
    w_legal = ((w_t & (w_t + WIDTH'(1))) == '0);
    w_cnt   = '0;
    for (int i = 0; i < WIDTH; i++) w_cnt = w_cnt + IDX_W'(w_t[i]);
    w_idx   = q_in[WIDTH-1] ? (IDX_W'(WIDTH) + w_cnt) : w_cnt;
    w_inc   = (state_idx == LAST) ? '0 : state_idx + IDX_W'(1);
    // state_idx doubles as the previous legal index p
    w_adv_ok = !r_first && (w_idx == w_inc);
    w_hold   = !r_first && (w_idx == state_idx);
  end

  always_comb begin
    w_state_nx = r_state;
    w_adv_nx   = r_adv;
    w_first_nx = r_first;
    w_idx_nx   = state_idx;
    w_oh_nx    = one_hot;
    w_valid_nx = valid;
    w_wrap_nx  = wrap_cnt;
    w_ill_nx   = 1'b0;
    w_seq_nx   = 1'b0;
    if (en) begin
      if (!w_legal) begin
        w_ill_nx   = 1'b1;
        w_valid_nx = 1'b0;
        w_oh_nx    = '0;
        w_state_nx = UNLOCKED;
        w_adv_nx   = '0;
        w_first_nx = 1'b1;
      end else begin
        w_valid_nx        = 1'b1;
        w_idx_nx          = w_idx;
        w_oh_nx           = '0;
        w_oh_nx[w_idx]    = 1'b1;
        w_first_nx        = 1'b0;
        case (r_state)
          UNLOCKED: begin
            if (w_adv_ok)     w_adv_nx = r_adv + 3'd1;
            else if (!w_hold) w_adv_nx = '0;
            if (w_adv_nx == 3'(LOCK_CNT)) begin
              w_state_nx = LOCKED;
              w_adv_nx   = '0;
            end
          end
          LOCKED: begin
            if (w_adv_ok && (w_idx == '0)) begin
              w_wrap_nx = wrap_cnt + CNT_W'(1);
            end else if (!w_adv_ok && !w_hold) begin
              w_seq_nx   = 1'b1;
              w_state_nx = UNLOCKED;
              w_adv_nx   = '0;
              w_first_nx = 1'b1;
            end
          end
          default: w_state_nx = UNLOCKED;
        endcase
      end
    end
    // a new error in the same cycle beats clr_err
    w_sticky_nx = (sticky_err & ~clr_err) | w_ill_nx | w_seq_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= UNLOCKED;
      r_adv      <= '0;
      r_first    <= 1'b1;
      state_idx  <= '0;
      one_hot    <= '0;
      valid      <= 1'b0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      wrap_cnt   <= '0;
      sticky_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_adv      <= w_adv_nx;
      r_first    <= w_first_nx;
      state_idx  <= w_idx_nx;
      one_hot    <= w_oh_nx;
      valid      <= w_valid_nx;
      illegal    <= w_ill_nx;
      seq_err    <= w_seq_nx;
      wrap_cnt   <= w_wrap_nx;
      sticky_err <= w_sticky_nx;
    end
  end

  assign locked = (r_state == LOCKED);

endmodule

// File: tb/tb_johnson_code_monitor.sv
// Bench for johnson_code_monitor: directed scenarios then random traffic,
// checked against a table-lookup reference model.
module tb_johnson_code_monitor;
  localparam int WIDTH = 4, IDX_W = 3, LOCK_CNT = 2, CNT_W = 8, N = 8;

  logic clk = 0, reset = 0, en = 0, clr_err = 0;
  logic [WIDTH-1:0]   q_in = '0;
  logic [IDX_W-1:0]   state_idx;
  logic [2*WIDTH-1:0] one_hot;
  logic valid, illegal, seq_err, locked, sticky_err;
  logic [CNT_W-1:0]   wrap_cnt;

  johnson_code_monitor #(.WIDTH(WIDTH), .IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
    .state_idx(state_idx), .one_hot(one_hot), .valid(valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .wrap_cnt(wrap_cnt), .sticky_err(sticky_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // reference model state
  logic [3:0] jc [N];
  int m_idx, m_oh, m_valid, m_ill, m_seq, m_locked, m_wrap, m_sticky;
  int m_adv, m_first;

  function automatic int lookup(input logic [3:0] q);
    for (int k = 0; k < N; k++) if (jc[k] == q) return k;
    return -1;
  endfunction

  task automatic model(input logic r, input logic e, input logic [3:0] q, input logic c);
    int k, was_first;
    bit adv, hold;
    if (r) begin
      m_idx = 0; m_oh = 0; m_valid = 0; m_ill = 0; m_seq = 0; m_locked = 0;
      m_wrap = 0; m_sticky = 0; m_adv = 0; m_first = 1;
      return;
    end
    m_ill = 0; m_seq = 0;
    if (e) begin
      k = lookup(q);
      if (k < 0) begin
        m_ill = 1; m_valid = 0; m_oh = 0; m_locked = 0; m_adv = 0; m_first = 1;
      end else begin
        was_first = m_first;
        adv  = !was_first && (k == (m_idx + 1) % N);
        hold = !was_first && (k == m_idx);
        m_first = 0;
        if (m_locked) begin
          if (adv && k == 0) m_wrap = (m_wrap + 1) % 256;
          else if (!adv && !hold) begin
            m_seq = 1; m_locked = 0; m_adv = 0; m_first = 1;
          end
        end else begin
          if (adv) m_adv++;
          else if (!hold) m_adv = 0;
          if (m_adv == LOCK_CNT) begin m_locked = 1; m_adv = 0; end
        end
        m_idx = k; m_valid = 1; m_oh = 1 << k;
      end
    end
    m_sticky = (m_sticky && !c) || m_ill || m_seq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] q, input logic c);
    reset = r; en = e; q_in = q; clr_err = c;
    @(posedge clk);
    model(r, e, q, c);
    #1;
    chk("state_idx", 32'(state_idx), 32'(m_idx));
    chk("one_hot", 32'(one_hot), 32'(m_oh));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("seq_err", 32'(seq_err), 32'(m_seq));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
    chk("sticky_err", 32'(sticky_err), 32'(m_sticky));
  endtask

  initial begin
    logic [3:0] q;
    int guard;
    jc[0] = 4'b0000;
    for (int k = 1; k < N; k++) jc[k] = {jc[k-1][2:0], ~jc[k-1][3]};
    #2;
    // reset and lock-in
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, jc[i], 0);
    // two full wraps while locked, then advance to idx 3
    for (int i = 4; i <= 19; i++) step(0, 1, jc[i % N], 0);
    // jump 3 -> 6
    step(0, 1, 4'b1100, 0);
    // illegal code, then relock
    step(0, 1, 4'b0101, 0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0011, 0);
    step(0, 1, 4'b0111, 0);
    // en low: outputs freeze regardless of q_in
    for (int i = 0; i < 5; i++) step(0, 0, 4'($urandom), 0);
    step(0, 0, 4'b1011, 1);
    // clear coinciding with a seq_err: set wins
    step(0, 1, 4'b1100, 1);
    // relock and run up to wrap_cnt = 5
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0011, 0);
    guard = 0;
    while (m_wrap < 5 && guard < 100) begin
      step(0, 1, jc[(m_idx + 1) % N], 0);
      guard++;
    end
    chk("wrap_reach5", 32'(wrap_cnt), 32'd5);
    step(1, 1, 4'b1111, 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    q = 4'($urandom);
        2:       q = jc[m_idx];
        default: q = jc[(m_idx + 1) % N];
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), q,
           ($urandom_range(0, 9) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
